// File: rtl/fpnorm_pkg.sv
// Shared types and shift-clamp helper for the FPU normalizer and the rounding-stage model.
package fpnorm_pkg;

  localparam int unsigned FP_MAN_W   = 24;
  localparam int unsigned FP_EXP_W   = 10;
  localparam int unsigned FP_SHAMT_W = $clog2(FP_MAN_W);

  localparam logic signed [FP_EXP_W:0] FP_EXP_ONE = $signed({{FP_EXP_W{1'b0}}, 1'b1});

  typedef struct packed {
    logic [FP_MAN_W-1:0]        mant;
    logic signed [FP_EXP_W-1:0] exp;
    logic [FP_SHAMT_W-1:0]      cnt;
    logic                       empty;
  } fpnorm_a_t;

  typedef struct packed {
    logic [FP_MAN_W-1:0]        mant;
    logic signed [FP_EXP_W-1:0] exp;
    logic                       zero;
    logic                       denorm;
  } fpnorm_out_t;

  // Left-shift amount limited so the exponent never falls below the minimum normal (1).
  function automatic logic [FP_SHAMT_W-1:0] clamp_shamt(
    input logic signed [FP_EXP_W-1:0] exp,
    input logic [FP_SHAMT_W-1:0]      cnt
  );
    logic signed [FP_EXP_W:0] e;
    logic signed [FP_EXP_W:0] c;
    e = $signed({exp[FP_EXP_W-1], exp});
    c = $signed({{(FP_EXP_W+1-FP_SHAMT_W){1'b0}}, cnt});
    if (e <= FP_EXP_ONE)
      return '0;
    else if ((e - c) >= FP_EXP_ONE)
      return cnt;
    else
      return FP_SHAMT_W'(e - FP_EXP_ONE);
  endfunction

endpackage

// File: rtl/fpnorm_pipe_lzc.sv
// Leading/trailing zero counter: MODE=1 counts from the MSB, MODE=0 from the LSB.
module lzc #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned MODE  = 1
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] cnt_o,
  output logic                     empty_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] scan;

  // scan[k] is the k-th bit visited in count order
  for (genvar g = 0; g < WIDTH; g++) begin : g_scan
    if (MODE != 0) begin : g_msb
      assign scan[g] = in_i[WIDTH-1-g];
    end else begin : g_lsb
      assign scan[g] = in_i[g];
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (scan[i]) cnt_o = CW'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/fpnorm_pipe.sv
// Two-stage normalizer: stage A counts leading zeros, stage B shifts with exponent clamp.
module fpnorm_pipe
  import fpnorm_pkg::*;
#(
  parameter int unsigned MAN_WIDTH = FP_MAN_W,
  parameter int unsigned EXP_WIDTH = FP_EXP_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [MAN_WIDTH-1:0]        mant_i,
  input  logic signed [EXP_WIDTH-1:0] exp_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [MAN_WIDTH-1:0]        mant_o,
  output logic signed [EXP_WIDTH-1:0] exp_o,
  output logic                        zero_o,
  output logic                        denorm_o
);

  localparam int unsigned SHAMT_WIDTH = $clog2(MAN_WIDTH);

  // Stage payloads are the shared package types, so widths must agree with them.
  if (MAN_WIDTH != FP_MAN_W || EXP_WIDTH != FP_EXP_W || MAN_WIDTH < 2) begin : g_width_check
    $error("fpnorm_pipe: widths must match fpnorm_pkg and MAN_WIDTH >= 2");
  end

  fpnorm_a_t   a_q;
  fpnorm_out_t b_q;
  fpnorm_out_t b_d;
  logic        a_valid_q;
  logic        b_valid_q;
  logic        b_ready;

  logic [SHAMT_WIDTH-1:0] lz_cnt;
  logic                   lz_empty;
  logic [SHAMT_WIDTH-1:0] shamt;

  lzc #(
    .WIDTH(MAN_WIDTH),
    .MODE (1)
  ) u_lzc (
    .in_i   (mant_i),
    .cnt_o  (lz_cnt),
    .empty_o(lz_empty)
  );

  assign b_ready    = ~b_valid_q | out_ready_i;
  assign in_ready_o = flush_i | ~a_valid_q | b_ready;

  // Stage A: capture operand together with its leading-zero count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_valid_q <= 1'b0;
      a_q       <= '0;
    end else if (flush_i) begin
      a_valid_q <= 1'b0;
    end else if (in_ready_o) begin
      a_valid_q <= in_valid_i;
      if (in_valid_i) begin
        a_q.mant  <= mant_i;
        a_q.exp   <= exp_i;
        a_q.cnt   <= lz_cnt;
        a_q.empty <= lz_empty;
      end
    end
  end

  // Stage B datapath: clamped barrel shift and exponent adjust
  always_comb begin
    shamt     = clamp_shamt(a_q.exp, a_q.cnt);
    b_d       = '0;
    b_d.mant  = a_q.mant << shamt;
    b_d.exp   = EXP_WIDTH'({a_q.exp[EXP_WIDTH-1], a_q.exp} - (EXP_WIDTH+1)'(shamt));
    b_d.denorm = (shamt != a_q.cnt);
    if (a_q.empty) begin
      b_d      = '0;
      b_d.zero = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_q <= 1'b0;
      b_q       <= '0;
    end else if (flush_i) begin
      b_valid_q <= 1'b0;
    end else if (b_ready) begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) b_q <= b_d;
    end
  end

  assign out_valid_o = b_valid_q;
  assign mant_o      = b_q.mant;
  assign exp_o       = b_q.exp;
  assign zero_o      = b_q.zero;
  assign denorm_o    = b_q.denorm;

endmodule

// File: doc/fpnorm_pipe.md
# fpnorm_pipe

Two-stage pipelined normalizer for the FPU datapath. Finds the leading one of an unnormalized mantissa with an `lzc` instance (leading-zero mode), left-shifts the mantissa and decrements the exponent. The shift is clamped so the result never drops below the minimum normal exponent, which gives gradual underflow. It sits between the FMA/add adder output and the rounding stage, and uses valid/ready handshakes on both sides.

## Interface
- `MAN_WIDTH`, default 24: mantissa width including the hidden bit; must be ≥ 2.
- `EXP_WIDTH`, default 10: signed biased exponent width.
- `SHAMT_WIDTH`, derived: `$clog2(MAN_WIDTH)`; not overridable.
- Clocking and reset (already decided): one clock, `clk_i`; reset `rst_ni` is asynchronous and active-low.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: async active-low reset.
- `flush_i`, in, 1: synchronous kill of all in-flight entries.
- `in_valid_i`, in, 1: input valid.
- `in_ready_o`, out, 1: input ready.
- `mant_i`, in, `MAN_WIDTH`: unnormalized mantissa; MSB is the hidden-bit position.
- `exp_i`, in, `EXP_WIDTH` (signed): exponent of `mant_i`.
- `out_valid_o`, out, 1: output valid.
- `out_ready_i`, in, 1: downstream ready.
- `mant_o`, out, `MAN_WIDTH`: normalized mantissa.
- `exp_o`, out, `EXP_WIDTH` (signed): adjusted exponent.
- `zero_o`, out, 1: `mant_i` was all zeros.
- `denorm_o`, out, 1: the shift was clamped; result is subnormal.

## Operation
**Stage A** (accept and count)
- On the handshake `in_valid_i & in_ready_o`, capture `mant_i` and `exp_i`.
- Also capture `cnt`: the `lzc` leading-zero count of `mant_i`, MSB first.
- Also capture `empty`: the `lzc` all-zero flag for `mant_i`.

**Stage B** (shift and adjust), computed from the Stage A registers and captured when Stage B accepts:
- If `empty`: `mant_o` = 0, `exp_o` = 0, `zero_o` = 1, `denorm_o` = 0.
- Else if `exp` ≤ 1: `shamt` = 0, `denorm_o` = (`cnt` ≠ 0).
- Else if `exp − cnt` ≥ 1: `shamt` = `cnt`, `denorm_o` = 0.
- Else: `shamt` = `exp − 1`, `denorm_o` = 1.
- `mant_o` = `mant << shamt`; zeros fill from the LSB.
- `exp_o` = `exp − shamt`.

**Arithmetic rules**
- Exponent arithmetic is done in `EXP_WIDTH+1` signed bits.
- `cnt` is zero-extended before subtraction.
- `exp_o` is never less than `min(exp, 1)`, so the subtraction cannot underflow.

**Handshake**
- Stage B is ready when it is empty or `out_ready_i` is high.
- `in_ready_o` = Stage A empty, or Stage B ready.
- Ready propagates combinationally backwards; there is no skid buffer.
- Full throughput: one transaction per cycle while `out_ready_i` = 1.
- While `out_valid_o` = 1 and `out_ready_i` = 0, all output fields hold stable.
- A simultaneous accept and drain in the same stage is legal; the new entry replaces the old one.

**Flush and reset**
- `flush_i` clears both valid bits on the next edge.
- An input handshake in the same cycle as `flush_i` is discarded.
- `in_ready_o` stays high during flush.
- Reset mid-operation discards all entries.
- Values after reset: `out_valid_o` = 0, `in_ready_o` = 1, and `mant_o`, `exp_o`, `zero_o`, `denorm_o` all = 0.
- Data registers are also reset, so no X appears on the outputs.

## Timing
- Latency is 2 cycles from input handshake to `out_valid_o`, with no back-pressure.
- Critical path: `lzc` tree into the Stage A register. The barrel shift and clamp logic sit in front of the Stage B register.
- No combinational path from any data input to any output.
- `in_ready_o` depends combinationally on `out_ready_i`.

## Structure
- Shared package `fpnorm_pkg` holds:
  - the `fpnorm_a_t` struct (`mant`, `exp`, `cnt`, `empty`);
  - the `fpnorm_out_t` struct (`mant`, `exp`, `zero`, `denorm`);
  - the function `clamp_shamt(exp, cnt)`, reused by the rounding stage model.
- One sub-module: `lzc` instantiated with `WIDTH = MAN_WIDTH`, `MODE = 1`. Its `cnt_o` and `empty_o` feed Stage A.
- The shifter is inline, not a separate module.

## Test plan
All cases use `MAN_WIDTH`=24, `EXP_WIDTH`=10.
1. `mant_i`=0x001000, `exp_i`=50, `out_ready_i`=1 → after 2 cycles: `mant_o`=0x800000, `exp_o`=39, `zero_o`=0, `denorm_o`=0.
2. `mant_i`=0x000100, `exp_i`=5 → `shamt` clamped to 4: `mant_o`=0x001000, `exp_o`=1, `denorm_o`=1. Also `mant_i`=0x400000, `exp_i`=1 → `mant_o`=0x400000, `exp_o`=1, `denorm_o`=1.
3. `mant_i`=0, `exp_i`=77 → `zero_o`=1, `mant_o`=0, `exp_o`=0.
4. Back-to-back stream of 8 inputs with `out_ready_i`=1 → 8 outputs on consecutive cycles, in order. Then hold `out_ready_i`=0 for 3 cycles → `in_ready_o` drops after 2 more accepts, outputs stay stable, and no data is lost or duplicated on release.
5. Assert `flush_i` with both stages full and `in_valid_i`=1 → next cycle `out_valid_o`=0 and the flushed/concurrent inputs never appear. Assert `rst_ni`=0 mid-stream → outputs go to zero and `in_ready_o`=1 asynchronously.
6. Randomized comparison against a reference model over 10k vectors, including `mant_i`=0x800000 (`shamt` 0) and `mant_i`=0x000001 with `exp_i`=200 (`shamt` 23, `exp_o`=177).
